// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch queue: fetches sequential instructions over a req/ack port,
// buffers up to DEPTH {pc, instr} pairs for IF_ID and flushes on branch redirect.
module if_prefetch_buffer #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic                     imem_ack,
    input  logic [INSTR_W-1:0]       imem_rdata,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
    localparam logic [INSTR_W-1:0] NOP     = INSTR_W'(32'h0000_0013);

    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [ADDR_W-1:0]  fetch_pc, fetch_pc_nxt;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count_nxt;
    logic               push, pop;

    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    assign imem_req  = (state != IDLE);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign push      = (state == BUSY) && imem_ack && !redirect_valid;
    assign out_pc    = pc_mem[rd_ptr];
    assign out_instr = out_valid ? instr_mem[rd_ptr] : NOP;

    always_comb begin
        count_nxt = count;
        if (redirect_valid)
            count_nxt = '0;
        else if (push && !pop)
            count_nxt = count + CNT_W'(1);
        else if (pop && !push)
            count_nxt = count - CNT_W'(1);
    end

    // A redirect always wins; a request still in flight must be drained in DROP.
    always_comb begin
        state_nxt    = state;
        addr_nxt     = imem_addr;
        fetch_pc_nxt = fetch_pc;
        if (redirect_valid) begin
            fetch_pc_nxt = redirect_pc;
            case (state)
                IDLE:    state_nxt = IDLE;
                BUSY:    state_nxt = imem_ack ? IDLE : DROP;
                DROP:    state_nxt = imem_ack ? IDLE : DROP;
                default: state_nxt = IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (count < DEPTH_C) begin
                        state_nxt = BUSY;
                        addr_nxt  = fetch_pc;
                    end
                end
                BUSY: begin
                    if (imem_ack) begin
                        fetch_pc_nxt = imem_addr + ADDR_W'(4);
                        if (count_nxt < DEPTH_C)
                            addr_nxt = imem_addr + ADDR_W'(4);
                        else
                            state_nxt = IDLE;
                    end
                end
                DROP: begin
                    if (imem_ack)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            state     <= state_nxt;
            imem_addr <= addr_nxt;
            fetch_pc  <= fetch_pc_nxt;
            count     <= count_nxt;
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Queue storage carries data only; validity comes from count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= imem_addr;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Bench for if_prefetch_buffer: directed vector table, hand-written corner sequences
// and a random run checked against a queue-based model of the fetch stream.
module tb_if_prefetch_buffer;
    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 64;
    localparam int          INSTR_W  = 32;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic               clk = 1'b0;
    logic               reset;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [2:0]         count;

    always #5 clk = ~clk;

    if_prefetch_buffer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .count(count)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        ack;
        logic        e_req;
        logic [63:0] e_addr;
        logic [2:0]  e_cnt;
        logic [63:0] e_pc;
    } vec_t;

    ent_t        q[$];
    logic [63:0] exp_next;
    logic        stale;
    logic        rv_last;
    int          idle_run;
    int          n_checks = 0;
    int          n_fail   = 0;
    vec_t        tbl[18];

    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        return a[31:0] + 32'h5000_0001;
    endfunction

    function automatic vec_t mk(input int rv, input logic [63:0] rpc, input int rdy,
                                input int ack, input int req, input logic [63:0] addr,
                                input int cnt, input logic [63:0] pc);
        vec_t v;
        v.rv = rv[0]; v.rpc = rpc; v.rdy = rdy[0]; v.ack = ack[0];
        v.e_req = req[0]; v.e_addr = addr; v.e_cnt = cnt[2:0]; v.e_pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_next = RESET_PC;
        stale    = 1'b0;
        rv_last  = 1'b0;
        idle_run = 0;
    endtask

    task automatic check_outputs();
        chk("count", 64'(count), 64'(q.size()));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_instr", 64'(out_instr), 64'(q[0].instr));
        end else begin
            chk("out_instr_nop", 64'(out_instr), 64'(NOP));
        end
        if (imem_req && !stale)
            chk("imem_addr", imem_addr, exp_next);
        if (q.size() == DEPTH)
            chk("req_when_full", 64'(imem_req), 64'd0);
        if (!imem_req && q.size() < DEPTH && !rv_last)
            idle_run++;
        else
            idle_run = 0;
        chk("req_latency", 64'(idle_run > 1), 64'd0);
    endtask

    // One clock: drive inputs, advance the model, then compare at the falling edge.
    task automatic tick(input int rv, input logic [63:0] rpc, input int rdy,
                        input int ack, input int raw);
        ent_t e;
        redirect_valid = rv[0];
        redirect_pc    = rpc;
        out_ready      = rdy[0];
        imem_ack       = raw[0] ? ack[0] : (ack[0] & imem_req);
        imem_rdata     = mem_fn(imem_addr);
        if (rv[0]) begin
            q.delete();
            stale    = imem_req && !imem_ack;
            exp_next = rpc;
        end else begin
            if (q.size() != 0 && rdy[0])
                void'(q.pop_front());
            if (imem_req && imem_ack) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    e.pc = exp_next;
                    e.instr = mem_fn(exp_next);
                    q.push_back(e);
                    exp_next = exp_next + 64'd4;
                end
            end
        end
        rv_last = rv[0];
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        tbl[0]  = mk(0, 64'h0,   1, 1, 1, 64'h0,   0, 64'h0);
        tbl[1]  = mk(0, 64'h0,   1, 1, 1, 64'h4,   1, 64'h0);
        tbl[2]  = mk(0, 64'h0,   1, 1, 1, 64'h8,   1, 64'h4);
        tbl[3]  = mk(0, 64'h0,   1, 1, 1, 64'hC,   1, 64'h8);
        tbl[4]  = mk(0, 64'h0,   0, 1, 1, 64'h10,  2, 64'h8);
        tbl[5]  = mk(0, 64'h0,   0, 1, 1, 64'h14,  3, 64'h8);
        tbl[6]  = mk(0, 64'h0,   0, 1, 0, 64'h0,   4, 64'h8);
        tbl[7]  = mk(0, 64'h0,   0, 1, 0, 64'h0,   4, 64'h8);
        tbl[8]  = mk(0, 64'h0,   1, 0, 0, 64'h0,   3, 64'hC);
        tbl[9]  = mk(0, 64'h0,   0, 0, 1, 64'h18,  3, 64'hC);
        tbl[10] = mk(0, 64'h0,   0, 0, 1, 64'h18,  3, 64'hC);
        tbl[11] = mk(0, 64'h0,   0, 1, 0, 64'h0,   4, 64'hC);
        tbl[12] = mk(0, 64'h0,   1, 0, 0, 64'h0,   3, 64'h10);
        tbl[13] = mk(0, 64'h0,   1, 1, 1, 64'h1C,  2, 64'h14);
        tbl[14] = mk(0, 64'h0,   1, 1, 1, 64'h20,  2, 64'h18);
        tbl[15] = mk(1, 64'h200, 1, 1, 0, 64'h0,   0, 64'h0);
        tbl[16] = mk(0, 64'h0,   1, 1, 1, 64'h200, 0, 64'h0);
        tbl[17] = mk(0, 64'h0,   1, 1, 1, 64'h204, 1, 64'h200);

        model_reset();
        reset = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        #1;
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_instr", 64'(out_instr), 64'(NOP));
        chk("rst_addr", imem_addr, RESET_PC);

        // Streaming, fill to full, drain, redirect with simultaneous ack
        do_reset();
        for (int i = 0; i < 18; i++) begin
            tick(int'(tbl[i].rv), tbl[i].rpc, int'(tbl[i].rdy), int'(tbl[i].ack), 0);
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_req", i), 64'(imem_req), 64'(tbl[i].e_req));
            if (tbl[i].e_req)
                chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
            if (tbl[i].e_cnt != 3'd0)
                chk($sformatf("vec%0d_pc", i), out_pc, tbl[i].e_pc);
        end

        // Redirect from IDLE: request for the target two cycles later
        do_reset();
        tick(1, 64'h80, 1, 0, 0);
        chk("idle_redir_req", 64'(imem_req), 64'd0);
        tick(0, 64'h0, 1, 0, 0);
        chk("idle_redir_addr", imem_addr, 64'h80);

        // Redirect while BUSY with a late ack: stale data must vanish
        do_reset();
        tick(0, 64'h0, 1, 0, 0);
        chk("t3_busy", 64'(imem_req), 64'd1);
        tick(1, 64'h200, 1, 0, 0);
        chk("t3_drop_req", 64'(imem_req), 64'd1);
        tick(0, 64'h0, 1, 0, 0);
        tick(0, 64'h0, 1, 0, 0);
        tick(0, 64'h0, 1, 1, 0);
        chk("t3_count", 64'(count), 64'd0);
        chk("t3_idle", 64'(imem_req), 64'd0);
        tick(0, 64'h0, 1, 0, 0);
        chk("t3_addr", imem_addr, 64'h200);
        tick(0, 64'h0, 0, 1, 0);
        chk("t3_out_pc", out_pc, 64'h200);
        chk("t3_out_cnt", 64'(count), 64'd1);

        // Two redirects back to back while draining the stale request
        do_reset();
        tick(0, 64'h0, 1, 0, 0);
        tick(1, 64'h100, 1, 0, 0);
        tick(1, 64'h300, 1, 0, 0);
        tick(0, 64'h0, 1, 1, 0);
        tick(0, 64'h0, 1, 0, 0);
        chk("t6_req", 64'(imem_req), 64'd1);
        chk("t6_addr", imem_addr, 64'h300);

        // Reset mid-request with two entries queued; a later ack is ignored
        do_reset();
        tick(0, 64'h0, 0, 1, 0);
        tick(0, 64'h0, 0, 1, 0);
        tick(0, 64'h0, 0, 1, 0);
        tick(0, 64'h0, 0, 0, 0);
        chk("t5_pre_count", 64'(count), 64'd2);
        chk("t5_pre_req", 64'(imem_req), 64'd1);
        reset = 1'b1;
        #1;
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_req", 64'(imem_req), 64'd0);
        chk("t5_count", 64'(count), 64'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        tick(0, 64'h0, 1, 1, 1);
        chk("t5_ack_ignored", 64'(count), 64'd0);
        chk("t5_first_addr", imem_addr, RESET_PC);
        tick(0, 64'h0, 0, 1, 0);
        chk("t5_first_pc", out_pc, RESET_PC);

        // Address wrap at the top of the address space
        do_reset();
        tick(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0);
        tick(0, 64'h0, 0, 1, 0);
        chk("wrap_addr_hi", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(0, 64'h0, 0, 1, 0);
        chk("wrap_addr_lo", imem_addr, 64'h0);
        chk("wrap_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int rv, rdy, ack;
            logic [63:0] rpc;
            if (i == 2000)
                do_reset();
            rv  = ($urandom_range(0, 15) == 0) ? 1 : 0;
            rpc = {$urandom(), $urandom()} & ~64'h3;
            if ((i / 300) % 2 == 0)
                rdy = ($urandom_range(0, 3) != 0) ? 1 : 0;
            else
                rdy = ($urandom_range(0, 3) == 0) ? 1 : 0;
            ack = ($urandom_range(0, 2) != 0) ? 1 : 0;
            tick(rv, rpc, rdy, ack, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
